// File: rtl/doorbell_sched.sv
// Coalesces SQ tail / CQ head updates and issues one doorbell request at a time.
// Request to done is set by the writer; a done, timeout or link drop is always followed by one GAP cycle.
module doorbell_sched #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = 16
) (
    input  logic             user_clk,
    input  logic             user_reset_n,
    input  logic             user_lnk_up,
    input  logic             sq_tail_upd,
    input  logic [IDX_W-1:0] sq_tail_val,
    input  logic             cq_head_upd,
    input  logic [IDX_W-1:0] cq_head_val,
    input  logic             err_clr,
    output logic             write_sqtdbl,
    output logic [63:0]      sqt_addr,
    output logic             write_cqhdbl,
    output logic [63:0]      cqh_addr,
    input  logic             write_sqtdbl_done,
    input  logic             write_cqhdbl_done,
    output logic             sq_pending,
    output logic             cq_pending,
    output logic             db_timeout_err,
    output logic [31:0]      db_issue_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t           state;
    logic [IDX_W-1:0] sq_val;
    logic [IDX_W-1:0] cq_val;
    logic             sq_req;
    logic             cq_req;
    logic             last_cq;
    logic [15:0]      tmr;

    logic pick_cq;
    logic sel;
    logic sel_sq;
    logic sel_cq;
    logic done_hit;
    logic abort;
    logic restore_sq;
    logic restore_cq;

    // On a tie, serve the queue that did not go last.
    assign pick_cq    = cq_pending & (~sq_pending | ~last_cq);
    assign sel        = (state == IDLE) & user_lnk_up & (sq_pending | cq_pending);
    assign sel_sq     = sel & ~pick_cq;
    assign sel_cq     = sel & pick_cq;
    assign done_hit   = (state == ISSUE) &
                        ((sq_req & write_sqtdbl_done) | (cq_req & write_cqhdbl_done));
    assign abort      = (state == ISSUE) & ~done_hit & (~user_lnk_up | (tmr == 16'd0));
    assign restore_sq = abort & sq_req;
    assign restore_cq = abort & cq_req;

    // Masking with done keeps the writer from seeing a request in the cycle it finishes.
    assign write_sqtdbl = sq_req & ~write_sqtdbl_done;
    assign write_cqhdbl = cq_req & ~write_cqhdbl_done;

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            sq_val     <= '0;
            cq_val     <= '0;
            sq_pending <= 1'b0;
            cq_pending <= 1'b0;
        end else begin
            // A fresh update beats both selection and an aborted value being put back.
            if (sq_tail_upd) begin
                sq_val     <= sq_tail_val;
                sq_pending <= 1'b1;
            end else if (sel_sq) begin
                sq_pending <= 1'b0;
            end else if (restore_sq && !sq_pending) begin
                sq_val     <= sqt_addr[IDX_W-1:0];
                sq_pending <= 1'b1;
            end

            if (cq_head_upd) begin
                cq_val     <= cq_head_val;
                cq_pending <= 1'b1;
            end else if (sel_cq) begin
                cq_pending <= 1'b0;
            end else if (restore_cq && !cq_pending) begin
                cq_val     <= cqh_addr[IDX_W-1:0];
                cq_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state          <= IDLE;
            sq_req         <= 1'b0;
            cq_req         <= 1'b0;
            sqt_addr       <= '0;
            cqh_addr       <= '0;
            last_cq        <= 1'b0;
            tmr            <= '0;
            db_issue_cnt   <= '0;
            db_timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel) begin
                        state <= ISSUE;
                        tmr   <= 16'(TIMEOUT_CYCLES - 1);
                        if (pick_cq) begin
                            cqh_addr <= 64'(cq_val);
                            cq_req   <= 1'b1;
                        end else begin
                            sqt_addr <= 64'(sq_val);
                            sq_req   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (done_hit) begin
                        sq_req       <= 1'b0;
                        cq_req       <= 1'b0;
                        last_cq      <= cq_req;
                        db_issue_cnt <= db_issue_cnt + 32'd1;
                        state        <= GAP;
                    end else if (abort) begin
                        sq_req <= 1'b0;
                        cq_req <= 1'b0;
                        state  <= GAP;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // A timeout in the same cycle as err_clr leaves the flag set.
            if (abort && user_lnk_up)
                db_timeout_err <= 1'b1;
            else if (err_clr)
                db_timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_doorbell_sched.sv
// Directed bench for doorbell_sched: a scoreboard of expected doorbells plus an auto-responding writer model.
module tb_doorbell_sched;

    logic        user_clk = 1'b0;
    logic        user_reset_n;
    logic        user_lnk_up;
    logic        sq_tail_upd;
    logic [15:0] sq_tail_val;
    logic        cq_head_upd;
    logic [15:0] cq_head_val;
    logic        err_clr;
    logic        write_sqtdbl;
    logic [63:0] sqt_addr;
    logic        write_cqhdbl;
    logic [63:0] cqh_addr;
    logic        write_sqtdbl_done;
    logic        write_cqhdbl_done;
    logic        sq_pending;
    logic        cq_pending;
    logic        db_timeout_err;
    logic [31:0] db_issue_cnt;

    logic resp_sq_done;
    logic resp_cq_done;
    logic man_sq_done;
    logic man_cq_done;
    logic auto_en;
    int   lat = 6;

    int errors = 0;
    int checks = 0;
    logic [16:0] expq[$];

    assign write_sqtdbl_done = resp_sq_done | man_sq_done;
    assign write_cqhdbl_done = resp_cq_done | man_cq_done;

    always #5 user_clk = ~user_clk;

    doorbell_sched #(.TIMEOUT_CYCLES(16), .IDX_W(16)) dut (
        .user_clk          (user_clk),
        .user_reset_n      (user_reset_n),
        .user_lnk_up       (user_lnk_up),
        .sq_tail_upd       (sq_tail_upd),
        .sq_tail_val       (sq_tail_val),
        .cq_head_upd       (cq_head_upd),
        .cq_head_val       (cq_head_val),
        .err_clr           (err_clr),
        .write_sqtdbl      (write_sqtdbl),
        .sqt_addr          (sqt_addr),
        .write_cqhdbl      (write_cqhdbl),
        .cqh_addr          (cqh_addr),
        .write_sqtdbl_done (write_sqtdbl_done),
        .write_cqhdbl_done (write_cqhdbl_done),
        .sq_pending        (sq_pending),
        .cq_pending        (cq_pending),
        .db_timeout_err    (db_timeout_err),
        .db_issue_cnt      (db_issue_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge user_clk);
        #1;
    endtask

    task automatic push_exp(input bit q, input logic [15:0] v);
        expq.push_back({q, v});
    endtask

    task automatic pulse_sq(input logic [15:0] v);
        sq_tail_val = v;
        sq_tail_upd = 1'b1;
        tick;
        sq_tail_upd = 1'b0;
    endtask

    task automatic pulse_cq(input logic [15:0] v);
        cq_head_val = v;
        cq_head_upd = 1'b1;
        tick;
        cq_head_upd = 1'b0;
    endtask

    task automatic wait_req(input bit cq);
        int n = 0;
        do begin
            @(negedge user_clk);
            n++;
        end while (!(cq ? write_cqhdbl : write_sqtdbl) && n < 60);
        chk(cq ? "wait_cq_req" : "wait_sq_req", 64'(n < 60), 64'd1);
    endtask

    task automatic wait_quiet;
        int q = 0;
        int n = 0;
        while (q < 5 && n < 400) begin
            @(negedge user_clk);
            n++;
            if (!write_sqtdbl && !write_cqhdbl && !sq_pending && !cq_pending) q++;
            else q = 0;
        end
        chk("quiet_bound", 64'(q >= 5), 64'd1);
        tick;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_reqs"}, {62'd0, write_sqtdbl, write_cqhdbl}, 64'd0);
        chk({tag, "_sqt_addr"}, sqt_addr, 64'd0);
        chk({tag, "_cqh_addr"}, cqh_addr, 64'd0);
        chk({tag, "_pend_err"}, {61'd0, sq_pending, cq_pending, db_timeout_err}, 64'd0);
        chk({tag, "_cnt"}, 64'(db_issue_cnt), 64'd0);
    endtask

    // Writer model: done pulses in the lat-th cycle a request is seen.
    initial begin
        int scnt = 0;
        int ccnt = 0;
        resp_sq_done = 1'b0;
        resp_cq_done = 1'b0;
        forever begin
            @(posedge user_clk);
            #1;
            resp_sq_done = 1'b0;
            resp_cq_done = 1'b0;
            if (!user_reset_n || !auto_en) begin
                scnt = 0;
                ccnt = 0;
            end else begin
                if (write_sqtdbl) begin
                    scnt++;
                    if (scnt == lat) begin
                        resp_sq_done = 1'b1;
                        scnt = 0;
                    end
                end else scnt = 0;
                if (write_cqhdbl) begin
                    ccnt++;
                    if (ccnt == lat) begin
                        resp_cq_done = 1'b1;
                        ccnt = 0;
                    end
                end else ccnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new request and checks hold, exclusivity and spacing.
    initial begin
        logic [16:0] e;
        logic        prev_sq = 1'b0;
        logic        prev_cq = 1'b0;
        logic [63:0] hold_sq = '0;
        logic [63:0] hold_cq = '0;
        int          lowcnt = 100;
        forever begin
            @(negedge user_clk);
            if (write_sqtdbl && !prev_sq) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_sq: got value %0h, nothing expected", sqt_addr);
                end else begin
                    e = expq.pop_front();
                    if (e !== {1'b0, sqt_addr[15:0]} || sqt_addr[63:16] !== 48'd0) begin
                        errors++;
                        $display("FAIL sb_issue_sq: got sq %0h expected q=%0d val %0h", sqt_addr, e[16], e[15:0]);
                    end
                end
                hold_sq = sqt_addr;
                chk("overlap_sq", 64'(write_cqhdbl), 64'd0);
                chk("gap_sq", 64'(lowcnt >= 2), 64'd1);
            end else if (write_sqtdbl) begin
                chk("hold_sqt_addr", sqt_addr, hold_sq);
            end
            if (write_cqhdbl && !prev_cq) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_cq: got value %0h, nothing expected", cqh_addr);
                end else begin
                    e = expq.pop_front();
                    if (e !== {1'b1, cqh_addr[15:0]} || cqh_addr[63:16] !== 48'd0) begin
                        errors++;
                        $display("FAIL sb_issue_cq: got cq %0h expected q=%0d val %0h", cqh_addr, e[16], e[15:0]);
                    end
                end
                hold_cq = cqh_addr;
                chk("overlap_cq", 64'(write_sqtdbl), 64'd0);
                chk("gap_cq", 64'(lowcnt >= 2), 64'd1);
            end else if (write_cqhdbl) begin
                chk("hold_cqh_addr", cqh_addr, hold_cq);
            end
            if (!write_sqtdbl && !write_cqhdbl) lowcnt++;
            else lowcnt = 0;
            prev_sq = write_sqtdbl;
            prev_cq = write_cqhdbl;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        user_reset_n = 1'b0;
        user_lnk_up  = 1'b0;
        sq_tail_upd  = 1'b0;
        sq_tail_val  = '0;
        cq_head_upd  = 1'b0;
        cq_head_val  = '0;
        err_clr      = 1'b0;
        man_sq_done  = 1'b0;
        man_cq_done  = 1'b0;
        auto_en      = 1'b1;
        #12;
        chk_zero_outs("reset");
        tick;
        user_reset_n = 1'b1;
        user_lnk_up  = 1'b1;
        tick;

        // Single SQ update: pending next cycle, request the cycle after.
        push_exp(1'b0, 16'h0005);
        sq_tail_val = 16'h0005;
        sq_tail_upd = 1'b1;
        tick;
        sq_tail_upd = 1'b0;
        chk("t1_pending", 64'(sq_pending), 64'd1);
        chk("t1_req_early", 64'(write_sqtdbl), 64'd0);
        tick;
        chk("t1_req", 64'(write_sqtdbl), 64'd1);
        chk("t1_addr", sqt_addr, 64'h5);
        n = 0;
        while (!write_sqtdbl_done && n < 60) begin
            @(negedge user_clk);
            n++;
        end
        chk("t1_done_seen", 64'(n < 60), 64'd1);
        chk("t1_mask_in_done", 64'(write_sqtdbl), 64'd0);
        tick;
        chk("t1_cnt", 64'(db_issue_cnt), 64'd1);
        chk("t1_pending_clr", 64'(sq_pending), 64'd0);
        wait_quiet;

        // Three SQ updates during a CQ doorbell coalesce to one with value 3.
        push_exp(1'b1, 16'h0020);
        pulse_cq(16'h0020);
        wait_req(1'b1);
        tick;
        push_exp(1'b0, 16'h0003);
        pulse_sq(16'h0001);
        pulse_sq(16'h0002);
        pulse_sq(16'h0003);
        wait_quiet;
        chk("t2_cnt", 64'(db_issue_cnt), 64'd3);

        // Asynchronous reset in the middle of a transaction.
        push_exp(1'b0, 16'h0077);
        pulse_sq(16'h0077);
        wait_req(1'b0);
        #2;
        user_reset_n = 1'b0;
        #1;
        chk_zero_outs("rst_async");
        tick;
        tick;
        user_reset_n = 1'b1;
        tick;

        // Simultaneous SQ and CQ from reset: CQ first, then SQ.
        push_exp(1'b1, 16'h00A1);
        push_exp(1'b0, 16'h005A);
        sq_tail_val = 16'h005A;
        cq_head_val = 16'h00A1;
        sq_tail_upd = 1'b1;
        cq_head_upd = 1'b1;
        tick;
        sq_tail_upd = 1'b0;
        cq_head_upd = 1'b0;
        wait_quiet;
        chk("t3_cnt", 64'(db_issue_cnt), 64'd2);

        // Update in the selection cycle: 8 goes out, 9 stays pending.
        user_lnk_up = 1'b0;
        pulse_sq(16'h0008);
        tick;
        chk("t4_held_while_down", 64'({sq_pending, write_sqtdbl}), 64'b10);
        push_exp(1'b0, 16'h0008);
        push_exp(1'b0, 16'h0009);
        user_lnk_up = 1'b1;
        sq_tail_val = 16'h0009;
        sq_tail_upd = 1'b1;
        tick;
        sq_tail_upd = 1'b0;
        chk("t4_addr", sqt_addr, 64'h8);
        chk("t4_still_pending", 64'(sq_pending), 64'd1);
        wait_quiet;
        chk("t4_cnt", 64'(db_issue_cnt), 64'd4);

        // Timeout after 16 request cycles; late done ignored; value reissued.
        auto_en = 1'b0;
        push_exp(1'b0, 16'h000C);
        push_exp(1'b0, 16'h000C);
        pulse_sq(16'h000C);
        wait_req(1'b0);
        n = 0;
        while (write_sqtdbl && n < 100) begin
            n++;
            @(negedge user_clk);
        end
        chk("t5_req_len", 64'(n), 64'd16);
        chk("t5_err", 64'(db_timeout_err), 64'd1);
        chk("t5_pending_restored", 64'(sq_pending), 64'd1);
        man_sq_done = 1'b1;
        @(negedge user_clk);
        man_sq_done = 1'b0;
        auto_en = 1'b1;
        wait_quiet;
        chk("t5_cnt", 64'(db_issue_cnt), 64'd5);
        chk("t5_err_sticky", 64'(db_timeout_err), 64'd1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("t5_err_clr", 64'(db_timeout_err), 64'd0);

        // Link drop mid-ISSUE: request falls, no error, value reissued on link up.
        push_exp(1'b0, 16'h0033);
        push_exp(1'b0, 16'h0033);
        pulse_sq(16'h0033);
        wait_req(1'b0);
        @(negedge user_clk);
        user_lnk_up = 1'b0;
        @(negedge user_clk);
        chk("t6_req_drop", 64'(write_sqtdbl), 64'd0);
        chk("t6_no_err", 64'(db_timeout_err), 64'd0);
        chk("t6_pending", 64'(sq_pending), 64'd1);
        repeat (3) @(negedge user_clk);
        chk("t6_wait_link", 64'({write_sqtdbl, sq_pending}), 64'b01);
        user_lnk_up = 1'b1;
        wait_quiet;
        chk("t6_cnt", 64'(db_issue_cnt), 64'd6);
        chk("t6_err_final", 64'(db_timeout_err), 64'd0);

        chk("sb_empty", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
